// File: rtl/mc_controller_if.sv
// Control bundle between the multicycle main controller (master) and the MIPS datapath (slave).
interface mc_controller_if #(
  parameter int ICNT_W = 32
) ();
  logic [5:0]        opcode;
  logic [5:0]        funct;
  logic              zero;
  logic [3:0]        aluctrl;
  logic              alusrca;
  logic [1:0]        alusrcb;
  logic              zeroext;
  logic [1:0]        pcsrc;
  logic              pcen;
  logic              iord;
  logic              irwrite;
  logic              memwrite;
  logic              regwrite;
  logic              regdst;
  logic              memtoreg;
  logic              illegal;
  logic [3:0]        state;
  logic [ICNT_W-1:0] icount;

  modport master (
    input  opcode, funct, zero,
    output aluctrl, alusrca, alusrcb, zeroext, pcsrc, pcen, iord, irwrite,
           memwrite, regwrite, regdst, memtoreg, illegal, state, icount
  );

  modport slave (
    output opcode, funct, zero,
    input  aluctrl, alusrca, alusrcb, zeroext, pcsrc, pcen, iord, irwrite,
           memwrite, regwrite, regdst, memtoreg, illegal, state, icount
  );
endinterface

// File: rtl/mc_controller.sv
// Multicycle MIPS main control FSM with a retired-instruction counter.
// Define MC_CTRL_BNE_EN to decode bne (000101) as a branch; otherwise it is illegal.
module mc_controller #(
  parameter int ICNT_W = 32
) (
  input  logic           clk,
  input  logic           reset,
  mc_controller_if.master bus
);
  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD = 4'd3,
    S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_RTEX   = 4'd6,  S_RTWB  = 4'd7,
    S_BRANCH = 4'd8,  S_IMMEX  = 4'd9,  S_IMMWB  = 4'd10, S_JUMP  = 4'd11
  } state_t;

  typedef struct packed {
    logic [3:0] aluctrl;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic       zeroext;
    logic [1:0] pcsrc;
    logic       pcwrite;
    logic       branch;
    logic       iord;
    logic       irwrite;
    logic       memwrite;
    logic       regwrite;
    logic       regdst;
    logic       memtoreg;
  } ctrl_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_J     = 6'b000010;

  state_t            r_state;
  ctrl_t             r_ctrl;
  logic [ICNT_W-1:0] r_icount;

  state_t     w_next;
  state_t     w_tgt;
  ctrl_t      w_ctrl;
  logic       w_rt_legal;
  logic [3:0] w_rt_alu;
  logic       w_bne_legal;
  logic       w_illegal;
  logic       w_terminal;

`ifdef MC_CTRL_BNE_EN
  assign w_bne_legal = 1'b1;
`else
  assign w_bne_legal = 1'b0;
`endif

  always_comb begin
    w_rt_legal = 1'b1;
    w_rt_alu   = 4'b0010;
    case (bus.funct)
      6'b100000: w_rt_alu = 4'b0010;
      6'b100010: w_rt_alu = 4'b0110;
      6'b100100: w_rt_alu = 4'b0000;
      6'b100101: w_rt_alu = 4'b0001;
      6'b100110: w_rt_alu = 4'b1011;
      6'b100111: w_rt_alu = 4'b0101;
      6'b101010: w_rt_alu = 4'b1001;
      6'b000000: w_rt_alu = 4'b0011;
      6'b000010: w_rt_alu = 4'b0100;
      default:   w_rt_legal = 1'b0;
    endcase
  end

  always_comb begin
    w_next    = S_FETCH;
    w_illegal = 1'b0;
    case (r_state)
      S_FETCH:  w_next = S_DECODE;
      S_DECODE: begin
        case (bus.opcode)
          OP_LW, OP_SW:            w_next = S_MEMADR;
          OP_RTYPE:                if (w_rt_legal) w_next = S_RTEX; else w_illegal = 1'b1;
          OP_BEQ:                  w_next = S_BRANCH;
          OP_BNE:                  if (w_bne_legal) w_next = S_BRANCH; else w_illegal = 1'b1;
          OP_ADDI, OP_ANDI, OP_ORI: w_next = S_IMMEX;
          OP_J:                    w_next = S_JUMP;
          default:                 w_illegal = 1'b1;
        endcase
      end
      S_MEMADR: w_next = (bus.opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  w_next = S_MEMWB;
      S_RTEX:   w_next = S_RTWB;
      S_IMMEX:  w_next = S_IMMWB;
      default:  w_next = S_FETCH;
    endcase
  end

  assign w_terminal = (r_state == S_MEMWB) || (r_state == S_MEMWR) || (r_state == S_RTWB) ||
                      (r_state == S_BRANCH) || (r_state == S_IMMWB) || (r_state == S_JUMP);

  // Controls are decoded for the state being entered so they are flop outputs for its whole cycle.
  assign w_tgt = reset ? S_FETCH : w_next;

  always_comb begin
    w_ctrl         = '0;
    w_ctrl.aluctrl = 4'b0010;
    case (w_tgt)
      S_FETCH:  begin w_ctrl.irwrite = 1'b1; w_ctrl.pcwrite = 1'b1; w_ctrl.alusrcb = 2'b01; end
      S_DECODE: w_ctrl.alusrcb = 2'b11;
      S_MEMADR: begin w_ctrl.alusrca = 1'b1; w_ctrl.alusrcb = 2'b10; end
      S_MEMRD:  w_ctrl.iord = 1'b1;
      S_MEMWB:  begin w_ctrl.memtoreg = 1'b1; w_ctrl.regwrite = 1'b1; end
      S_MEMWR:  begin w_ctrl.iord = 1'b1; w_ctrl.memwrite = 1'b1; end
      S_RTEX:   begin w_ctrl.alusrca = 1'b1; w_ctrl.aluctrl = w_rt_alu; end
      S_RTWB:   begin w_ctrl.regdst = 1'b1; w_ctrl.regwrite = 1'b1; end
      S_BRANCH: begin
        w_ctrl.alusrca = 1'b1;
        w_ctrl.pcsrc   = 2'b01;
        w_ctrl.branch  = 1'b1;
        w_ctrl.aluctrl = (bus.opcode == OP_BNE) ? 4'b1111 : 4'b1101;
      end
      S_IMMEX:  begin
        w_ctrl.alusrca = 1'b1;
        w_ctrl.alusrcb = 2'b10;
        if (bus.opcode == OP_ANDI) begin
          w_ctrl.aluctrl = 4'b0000;
          w_ctrl.zeroext = 1'b1;
        end else if (bus.opcode == OP_ORI) begin
          w_ctrl.aluctrl = 4'b0001;
          w_ctrl.zeroext = 1'b1;
        end
      end
      S_IMMWB:  w_ctrl.regwrite = 1'b1;
      S_JUMP:   begin w_ctrl.pcsrc = 2'b10; w_ctrl.pcwrite = 1'b1; end
      default:  ;
    endcase
  end

  always_ff @(posedge clk) begin
    r_ctrl <= w_ctrl;
    if (reset) begin
      r_state  <= S_FETCH;
      r_icount <= '0;
    end else begin
      r_state <= w_next;
      if (w_terminal) r_icount <= r_icount + {{(ICNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Write enables are squashed while reset is high so an abandoned instruction cannot commit.
  assign bus.pcen     = (r_ctrl.pcwrite | (r_ctrl.branch & bus.zero)) & ~reset;
  assign bus.irwrite  = r_ctrl.irwrite & ~reset;
  assign bus.memwrite = r_ctrl.memwrite & ~reset;
  assign bus.regwrite = r_ctrl.regwrite & ~reset;
  assign bus.illegal  = (r_state == S_DECODE) & w_illegal & ~reset;
  assign bus.aluctrl  = r_ctrl.aluctrl;
  assign bus.alusrca  = r_ctrl.alusrca;
  assign bus.alusrcb  = r_ctrl.alusrcb;
  assign bus.zeroext  = r_ctrl.zeroext;
  assign bus.pcsrc    = r_ctrl.pcsrc;
  assign bus.iord     = r_ctrl.iord;
  assign bus.regdst   = r_ctrl.regdst;
  assign bus.memtoreg = r_ctrl.memtoreg;
  assign bus.state    = r_state;
  assign bus.icount   = r_icount;
endmodule

// File: tb/tb_mc_controller.sv
// Bench for mc_controller: table of instructions, hand-written reset/wrap sequences, random instruction stream.
module tb_mc_controller;
  localparam int W = 4;

  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  int   icnt   = 0;

  mc_controller_if #(.ICNT_W(W)) bus ();
  mc_controller #(.ICNT_W(W)) dut (.clk(clk), .reset(reset), .bus(bus.master));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] aluctrl;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic       zeroext;
    logic [1:0] pcsrc;
    logic       pcen;
    logic       iord;
    logic       irwrite;
    logic       memwrite;
    logic       regwrite;
    logic       regdst;
    logic       memtoreg;
    logic       illegal;
  } obs_t;

  typedef struct {
    logic [5:0] op;
    logic [5:0] fn;
    int         zmode;
    int         lat;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic obs_t sample();
    obs_t o;
    o.aluctrl = bus.aluctrl;   o.alusrca = bus.alusrca;   o.alusrcb = bus.alusrcb;
    o.zeroext = bus.zeroext;   o.pcsrc = bus.pcsrc;       o.pcen = bus.pcen;
    o.iord = bus.iord;         o.irwrite = bus.irwrite;   o.memwrite = bus.memwrite;
    o.regwrite = bus.regwrite; o.regdst = bus.regdst;     o.memtoreg = bus.memtoreg;
    o.illegal = bus.illegal;
    return o;
  endfunction

  function automatic logic [4:0] funct_alu(input logic [5:0] fn);
    // bit 4 = funct is supported
    case (fn)
      6'b100000: return 5'h10 | 5'b00010;
      6'b100010: return 5'h10 | 5'b00110;
      6'b100100: return 5'h10 | 5'b00000;
      6'b100101: return 5'h10 | 5'b00001;
      6'b100110: return 5'h10 | 5'b01011;
      6'b100111: return 5'h10 | 5'b00101;
      6'b101010: return 5'h10 | 5'b01001;
      6'b000000: return 5'h10 | 5'b00011;
      6'b000010: return 5'h10 | 5'b00100;
      default:   return 5'h00;
    endcase
  endfunction

  // 0 illegal, 1 lw, 2 sw, 3 R-type, 4 immediate, 5 branch, 6 jump
  function automatic int cls(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      6'b100011: return 1;
      6'b101011: return 2;
      6'b000000: return funct_alu(fn)[4] ? 3 : 0;
      6'b001000, 6'b001100, 6'b001101: return 4;
      6'b000100: return 5;
`ifdef MC_CTRL_BNE_EN
      6'b000101: return 5;
`endif
      6'b000010: return 6;
      default:   return 0;
    endcase
  endfunction

  function automatic int path_len(input logic [5:0] op, input logic [5:0] fn);
    int lens[7];
    lens = '{2, 5, 4, 4, 4, 3, 3};
    return lens[cls(op, fn)];
  endfunction

  function automatic int path_state(input logic [5:0] op, input logic [5:0] fn, input int k);
    int p[6];
    case (cls(op, fn))
      1:       p = '{0, 1, 2, 3, 4, 0};
      2:       p = '{0, 1, 2, 5, 0, 0};
      3:       p = '{0, 1, 6, 7, 0, 0};
      4:       p = '{0, 1, 9, 10, 0, 0};
      5:       p = '{0, 1, 8, 0, 0, 0};
      6:       p = '{0, 1, 11, 0, 0, 0};
      default: p = '{0, 1, 0, 0, 0, 0};
    endcase
    return (k >= 0 && k < 6) ? p[k] : 0;
  endfunction

  function automatic obs_t exp_ctrl(input int st, input logic [5:0] op, input logic [5:0] fn, input logic z);
    obs_t e;
    e = '0;
    e.aluctrl = 4'b0010;
    case (st)
      0:  begin e.irwrite = 1; e.pcen = 1; e.alusrcb = 2'b01; end
      1:  begin e.alusrcb = 2'b11; e.illegal = (cls(op, fn) == 0); end
      2:  begin e.alusrca = 1; e.alusrcb = 2'b10; end
      3:  e.iord = 1;
      4:  begin e.memtoreg = 1; e.regwrite = 1; end
      5:  begin e.iord = 1; e.memwrite = 1; end
      6:  begin e.alusrca = 1; e.aluctrl = funct_alu(fn)[3:0]; end
      7:  begin e.regdst = 1; e.regwrite = 1; end
      8:  begin
        e.alusrca = 1; e.pcsrc = 2'b01; e.pcen = z;
        e.aluctrl = (op == 6'b000100) ? 4'b1101 : 4'b1111;
      end
      9:  begin
        e.alusrca = 1; e.alusrcb = 2'b10;
        if (op == 6'b001100) begin e.aluctrl = 4'b0000; e.zeroext = 1; end
        if (op == 6'b001101) begin e.aluctrl = 4'b0001; e.zeroext = 1; end
      end
      10: e.regwrite = 1;
      11: begin e.pcsrc = 2'b10; e.pcen = 1; end
      default: ;
    endcase
    return e;
  endfunction

  // Entered #1 after the edge that starts a FETCH cycle; leaves at the same point of the next FETCH.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int zmode, input int exp_lat);
    int   n;
    int   lat;
    int   st;
    logic zv;
    bit   done;
    n    = path_len(op, fn);
    lat  = 0;
    done = 0;
    bus.opcode = op;
    bus.funct  = fn;
    for (int k = 0; k < 12 && !done; k++) begin
      zv = (zmode == 2) ? 1'($urandom_range(0, 1)) : 1'(zmode);
      bus.zero = zv;
      #1;
      st = (k < n) ? path_state(op, fn, k) : 0;
      chk($sformatf("state op=%b fn=%b k=%0d", op, fn, k), 32'(bus.state), 32'(st));
      chk($sformatf("ctrl op=%b fn=%b st=%0d", op, fn, st), 32'(sample()), 32'(exp_ctrl(st, op, fn, zv)));
      step();
      if (bus.state == 4'd0) begin
        done = 1;
        lat  = k + 1;
      end
    end
    if (!done) chk("timeout_return_to_fetch", 32'(0), 32'(1));
    chk($sformatf("latency op=%b fn=%b", op, fn), 32'(lat), 32'((exp_lat >= 0) ? exp_lat : n));
    if (cls(op, fn) != 0) icnt = (icnt + 1) % (1 << W);
    chk("icount", 32'(bus.icount), 32'(icnt));
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

  initial begin
    logic [5:0] ops[10];
    logic [5:0] fns[9];
    logic [5:0] op;
    logic [5:0] fn;
    int         r;

    ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b000101,
            6'b001000, 6'b001100, 6'b001101, 6'b000010, 6'b111111};
    fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100110,
            6'b100111, 6'b101010, 6'b000000, 6'b000010};

    vecs.push_back('{6'b100011, 6'b000000, 0, 5});
    vecs.push_back('{6'b101011, 6'b000000, 0, 4});
    vecs.push_back('{6'b000000, 6'b100111, 0, 4});
    vecs.push_back('{6'b000000, 6'b100000, 1, 4});
    vecs.push_back('{6'b000000, 6'b101010, 0, 4});
    vecs.push_back('{6'b000000, 6'b000000, 0, 4});
    vecs.push_back('{6'b000000, 6'b000010, 0, 4});
    vecs.push_back('{6'b000000, 6'b111111, 0, 2});
    vecs.push_back('{6'b000100, 6'b000000, 1, 3});
    vecs.push_back('{6'b000100, 6'b000000, 0, 3});
`ifdef MC_CTRL_BNE_EN
    vecs.push_back('{6'b000101, 6'b000000, 1, 3});
`else
    vecs.push_back('{6'b000101, 6'b000000, 1, 2});
`endif
    vecs.push_back('{6'b001000, 6'b000000, 0, 4});
    vecs.push_back('{6'b001100, 6'b000000, 0, 4});
    vecs.push_back('{6'b001101, 6'b000000, 0, 4});
    vecs.push_back('{6'b000010, 6'b000000, 0, 3});
    vecs.push_back('{6'b111111, 6'b100000, 0, 2});

    reset = 1'b1;
    bus.opcode = 6'b100011;
    bus.funct  = 6'b000000;
    bus.zero   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("reset_enables", 32'({bus.pcen, bus.irwrite, bus.memwrite, bus.regwrite, bus.illegal}), 32'(0));
    end
    chk("reset_state", 32'(bus.state), 32'(0));
    chk("reset_icount", 32'(bus.icount), 32'(0));
    reset = 1'b0;
    #1;
    chk("first_fetch", 32'(sample()), 32'(exp_ctrl(0, 6'b100011, 6'b000000, 1'b1)));

    foreach (vecs[i]) run_instr(vecs[i].op, vecs[i].fn, vecs[i].zmode, vecs[i].lat);

    // Reset arriving in MEMRD of a lw must abandon it without the MEMWB register write.
    bus.opcode = 6'b100011;
    bus.funct  = 6'b000000;
    step(); step(); step();
    chk("midreset_in_memrd", 32'(bus.state), 32'(3));
    reset = 1'b1;
    #1;
    chk("midreset_gated", 32'({bus.pcen, bus.irwrite, bus.memwrite, bus.regwrite, bus.illegal}), 32'(0));
    step();
    chk("midreset_state", 32'(bus.state), 32'(0));
    chk("midreset_no_regwrite", 32'({bus.regwrite, bus.memwrite, bus.pcen}), 32'(0));
    chk("midreset_icount", 32'(bus.icount), 32'(0));
    icnt  = 0;
    reset = 1'b0;
    #1;
    chk("midreset_fetch_regwrite", 32'(bus.regwrite), 32'(0));

    for (int i = 0; i < (1 << W) - 1; i++) run_instr(6'b000010, 6'b000000, 2, 3);
    chk("icount_all_ones", 32'(bus.icount), 32'((1 << W) - 1));
    run_instr(6'b000100, 6'b000000, 0, 3);
    chk("icount_wrap", 32'(bus.icount), 32'(0));

    for (int i = 0; i < 40; i++) begin
      r  = $urandom_range(0, 9);
      op = (r == 9) ? 6'($urandom_range(0, 63)) : ops[r];
      fn = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : fns[$urandom_range(0, 8)];
      run_instr(op, fn, 2, -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mc_controller.md
# mc_controller

Multicycle main control FSM for the MIPS datapath. Sits directly upstream of the 32-bit ALU. Each cycle it decodes the instruction register's opcode/funct fields and drives the ALU's `aluctrl`, the datapath mux selects and the write enables. The ALU's combinational `zero` flag is fed back to qualify branches. A retired-instruction counter is also maintained.

## Interface
Parameters:
- `ICNT_W`, default 32: retired-instruction counter width.

Ports:
- `clk` in 1: single clock; the state register updates on posedge.
- `reset` in 1: synchronous, active-high.
- `opcode` in 6: IR[31:26].
- `funct` in 6: IR[5:0].
- `zero` in 1: ALU zero flag, combinational.
- `aluctrl` out 4: ALU operation code.
- `alusrca` out 1: 0=PC, 1=A.
- `alusrcb` out 2: 00=B, 01=4, 10=SignImm, 11=SignImm<<2.
- `zeroext` out 1: immediate is zero-extended, not sign-extended.
- `pcsrc` out 2: 00=ALU, 01=ALUOut, 10=jump target.
- `pcen` out 1: PC write enable, computed as pcwrite | (branch & zero).
- `iord`, `irwrite`, `memwrite`, `regwrite`, `regdst`, `memtoreg` out 1 each: standard multicycle controls.
- `illegal` out 1: one-cycle pulse in DECODE for an unsupported opcode/funct.
- `state` out 4: current state, for debug.
- `icount` out ICNT_W: retired-instruction count.

## Operation
- Opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, bne 000101, addi 001000, andi 001100, ori 001101, j 000010.
- R-type funct to `aluctrl`:
  - add 100000 -> 0010
  - sub 100010 -> 0110
  - and 100100 -> 0000
  - or 100101 -> 0001
  - xor 100110 -> 1011
  - nor 100111 -> 0101
  - slt 101010 -> 1001
  - sll 000000 -> 0011
  - srl 000010 -> 0100
  - Any other funct is illegal.
- States (encoding): FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, RTEX 6, RTWB 7, BRANCH 8, IMMEX 9, IMMWB 10, JUMP 11. Codes 12-15 are unreachable and go to FETCH.
- Transitions:
  - FETCH -> DECODE.
  - DECODE -> MEMADR (lw/sw), RTEX, BRANCH, IMMEX (addi/andi/ori), JUMP, or FETCH (illegal).
  - MEMADR -> MEMRD (lw) or MEMWR (sw).
  - MEMRD -> MEMWB.
  - RTEX -> RTWB.
  - IMMEX -> IMMWB.
  - MEMWB, MEMWR, RTWB, BRANCH, IMMWB, JUMP -> FETCH.
- Outputs are a Moore decode of state, plus opcode/funct in RTEX, BRANCH and IMMEX. Defaults: all enables 0, selects 0, `aluctrl`=0010.
  - FETCH: irwrite=1, pcwrite=1, alusrcb=01, add.
  - DECODE: alusrcb=11, add. This computes the branch target.
  - MEMADR: alusrca=1, alusrcb=10, add.
  - MEMRD: iord=1.
  - MEMWB: memtoreg=1, regwrite=1.
  - MEMWR: iord=1, memwrite=1.
  - RTEX: alusrca=1, alusrcb=00, `aluctrl` from funct.
  - RTWB: regdst=1, regwrite=1.
  - BRANCH: alusrca=1, alusrcb=00, pcsrc=01, branch=1, `aluctrl`=1101 for beq or 1111 for bne.
  - IMMEX: alusrca=1, alusrcb=10, `aluctrl` 0010/0000/0001 for addi/andi/ori; zeroext=1 for andi/ori.
  - IMMWB: regwrite=1.
  - JUMP: pcsrc=10, pcwrite=1.
- `icount` increments by 1 on every transition from a terminal state to FETCH. It wraps from all-ones to 0. Illegal instructions do not count.

## Timing
- Reset (checked at posedge): state=FETCH, icount=0. While `reset`=1, pcen, irwrite, memwrite, regwrite and illegal are forced to 0. This also applies when reset asserts mid-instruction: the instruction is abandoned and no write occurs after the reset edge.
- The first FETCH with enables active is in the cycle after `reset` deasserts.
- Controls are stable for the whole cycle. The ALU latches its result on negedge, so it sees settled `aluctrl`/selects.
- `zero` is sampled combinationally in BRANCH only: pcen = zero during BRANCH.
- Instruction latency (cycles, including FETCH):
  - lw 5
  - sw 4
  - R-type 4
  - addi/andi/ori 4
  - beq/bne 3
  - j 3
  - illegal 2

## Configuration
- `MC_CTRL_BNE_EN` defined: bne (000101) is decoded into BRANCH with `aluctrl`=1111.
- `MC_CTRL_BNE_EN` undefined: opcode 000101 is illegal. DECODE pulses `illegal` and returns to FETCH; no PC or register write occurs.

## Test plan
- Hold reset 3 cycles, then release: state=0, icount=0, all enables 0 during reset; next cycle irwrite=1, pcen=1, aluctrl=0010, alusrcb=01.
- lw (100011): states 0,1,2,3,4,0; MEMRD iord=1; MEMWB regwrite=1 and memtoreg=1; icount +1.
- R-type funct 100111: RTEX aluctrl=0101; RTWB regwrite=1 and regdst=1; 4 cycles total. Repeat for funct 111111: illegal=1 in DECODE, then FETCH, icount unchanged.
- beq with zero=1: BRANCH pcen=1, pcsrc=01, aluctrl=1101. With zero=0: pcen=0.
- bne with macro defined: BRANCH aluctrl=1111. With macro undefined: illegal pulse, no BRANCH state.
- Reset asserted in MEMRD of lw: next state FETCH, regwrite never asserted. Separately, preload icount=2^ICNT_W-1 and retire one instruction: icount=0.
